// File: rtl/hub_adder_scheduler.sv
// hub_adder_scheduler: shares one fixed-latency pipelined FP HUB adder among
// N requesters. Grants are round-robin, and subtraction flips the sign of Y.
// The requester tag travels alongside each operation, and results land in a
// first-word-fall-through response FIFO. A credit counter bounds the number
// of outstanding operations to the FIFO depth, so no result is ever dropped.
module hub_adder_scheduler #(
  parameter int M     = 23,
  parameter int E     = 8,
  parameter int N     = 4,
  parameter int LAT   = 3,
  parameter int DEPTH = 8,
  parameter int TW    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [N*(E+M+1)-1:0]  req_x,
  input  logic [N*(E+M+1)-1:0]  req_y,
  input  logic [N-1:0]          req_sub,
  output logic                  add_valid,
  output logic [E+M:0]          add_x,
  output logic [E+M:0]          add_y,
  input  logic [E+M:0]          add_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [E+M:0]          rsp_data,
  output logic [TW-1:0]         rsp_tag
);

  localparam int W  = E + M + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  // (p + k) mod N for k < N; keeps the index TW bits wide for any N
  function automatic logic [TW-1:0] wrap_idx(input logic [TW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return TW'(s);
  endfunction

  // ---------------------------------------------------------------------
  // Credits and round-robin arbitration
  // ---------------------------------------------------------------------
  logic [TW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] gnt_idx;
  logic          gnt_found;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          can_issue;
  logic          issue;
  logic          pop;
  logic          push;
  logic [W-1:0]  sel_x, sel_y;

  // a pop in this cycle does not free a credit until next cycle
  assign can_issue = (cnt_q < CW'(DEPTH));

  // find the first valid requester at or after ptr, wrapping; the descending
  // scan leaves the smallest offset as the winner
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(ptr_q, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(ptr_q, k);
      end
    end
  end

  assign req_ready = (!rst && can_issue && gnt_found)
                     ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign issue     = |req_ready;

  assign sel_x = req_x[int'(gnt_idx)*W +: W];
  assign sel_y = req_y[int'(gnt_idx)*W +: W];

  // next pointer and credit count
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (issue) ptr_d = wrap_idx(gnt_idx, 1);
    if (issue && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!issue && pop) cnt_d = cnt_q - CW'(1);
  end

  // pointer and credit registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Issue stage: operands are registered, and Y gets its sign flipped for subtraction
  // ---------------------------------------------------------------------
  logic          add_valid_q;
  logic [W-1:0]  add_x_q, add_y_q;
  logic [TW-1:0] iss_tag_q;

  // register the granted operands; operands hold their value when nothing issues
  always_ff @(posedge clk) begin
    if (rst) begin
      add_valid_q <= 1'b0;
      add_x_q     <= '0;
      add_y_q     <= '0;
      iss_tag_q   <= '0;
    end else begin
      add_valid_q <= issue;
      if (issue) begin
        add_x_q   <= sel_x;
        add_y_q   <= {sel_y[W-1] ^ req_sub[gnt_idx], sel_y[W-2:0]};
        iss_tag_q <= gnt_idx;
      end
    end
  end

  assign add_valid = add_valid_q;
  assign add_x     = add_x_q;
  assign add_y     = add_y_q;

  // ---------------------------------------------------------------------
  // Tag pipeline: mirrors the adder latency so the tag meets its result
  // ---------------------------------------------------------------------
  logic [LAT:1]  vld_pipe_q;
  logic [TW-1:0] tag_pipe_q [LAT:1];

  // shift {valid, tag} alongside the adder; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      for (int s = 1; s <= LAT; s++) tag_pipe_q[s] <= '0;
    end else begin
      vld_pipe_q[1] <= add_valid_q;
      tag_pipe_q[1] <= iss_tag_q;
      for (int s = 2; s <= LAT; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        tag_pipe_q[s] <= tag_pipe_q[s-1];
      end
    end
  end

  // add_result is only trusted in the cycle its own op leaves the pipe
  assign push = vld_pipe_q[LAT];

  // ---------------------------------------------------------------------
  // Response FIFO (first-word fall-through)
  // ---------------------------------------------------------------------
  logic [W-1:0]  mem_data [DEPTH];
  logic [TW-1:0] mem_tag  [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] fill_q;
  logic          fifo_empty;

  assign fifo_empty = (fill_q == '0);
  assign pop        = !fifo_empty && rsp_ready;

  // storage carries no reset; the fill count alone decides what is valid
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_data[wr_ptr_q] <= add_result;
      mem_tag[wr_ptr_q]  <= tag_pipe_q[LAT];
    end
  end

  // pointers and fill level; simultaneous push and pop both take effect
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      fill_q <= fill_q + CW'(1);
      else if (!push && pop) fill_q <= fill_q - CW'(1);
    end
  end

  // head is shown as zero while empty so reset state reads clean
  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_empty ? '0 : mem_data[rd_ptr_q];
  assign rsp_tag   = fifo_empty ? '0 : mem_tag[rd_ptr_q];

endmodule

// File: tb/tb_hub_adder_scheduler.sv
// Bench for hub_adder_scheduler: a stand-in adder with fixed latency, a
// queue-based reference model checked every cycle, table-driven vectors, and
// hand sequences for round-robin order, backpressure, pointer skip, and mid-flight reset.
module tb_hub_adder_scheduler;
  localparam int M = 23, E = 8, N = 4, LAT = 3, DEPTH = 8, TW = 2;
  localparam int W = E + M + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_sub = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_x = '0;
  logic [N*W-1:0]   req_y = '0;
  logic             add_valid;
  logic [W-1:0]     add_x, add_y, add_result;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [W-1:0]     rsp_data;
  logic [TW-1:0]    rsp_tag;

  hub_adder_scheduler #(.M(M), .E(E), .N(N), .LAT(LAT), .DEPTH(DEPTH), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_sub(req_sub),
    .add_valid(add_valid), .add_x(add_x), .add_y(add_y), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  // Stand-in adder arithmetic: any fixed function of the operands will do,
  // because the scheduler never looks inside the operands
  function automatic logic [W-1:0] fake_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x + {y[W-2:0], y[W-1]}) ^ 32'h5A5A_0F0F;
  endfunction

  // Stand-in adder pipeline: ignores reset, and shows junk when no result is due
  logic [LAT-1:0] av_p = '0;
  logic [W-1:0]   ad_p [LAT];
  logic [W-1:0]   junk = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    av_p[0] <= add_valid;
    ad_p[0] <= fake_add(add_x, add_y);
    for (int s = 1; s < LAT; s++) begin
      av_p[s] <= av_p[s-1];
      ad_p[s] <= ad_p[s-1];
    end
    junk <= $urandom;
  end
  assign add_result = av_p[LAT-1] ? ad_p[LAT-1] : junk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {logic [W-1:0] d; int tag; int due;} ent_t;
  ent_t     infl[$];
  ent_t     fq[$];
  int       m_cnt = 0, m_ptr = 0, m_cyc = 0;
  logic     m_av = 1'b0;
  logic [W-1:0] m_ax = '0, m_ay = '0;
  bit       m_known = 0;
  int       g_last = -1;
  bit       iss_last = 0, pop_last = 0;
  logic [N-1:0] exp_ready;
  int       got[$];

  task automatic model_check();
    int g;
    g = -1;
    exp_ready = '0;
    if (!rst && m_cnt < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    while (infl.size() > 0 && infl[0].due <= m_cyc) fq.push_back(infl.pop_front());
    if (m_known) begin
      chk("req_ready", req_ready, exp_ready);
      chk("add_valid", add_valid, m_av);
      chk("add_x", add_x, m_ax);
      chk("add_y", add_y, m_ay);
      chk("rsp_valid", rsp_valid, fq.size() > 0);
      if (fq.size() > 0) begin
        chk("rsp_data", rsp_data, fq[0].d);
        chk("rsp_tag", rsp_tag, fq[0].tag);
      end
    end
    g_last   = g;
    iss_last = (g >= 0);
    pop_last = (fq.size() > 0) && rsp_ready;
  endtask

  task automatic model_update();
    if (rst) begin
      m_cnt = 0; m_ptr = 0; m_av = 1'b0; m_ax = '0; m_ay = '0;
      infl.delete(); fq.delete();
      m_known = 1;
    end else begin
      if (pop_last) void'(fq.pop_front());
      m_av = iss_last;
      if (iss_last) begin
        logic [W-1:0] x, y;
        x = req_x[g_last*W +: W];
        y = req_y[g_last*W +: W];
        y[W-1] = y[W-1] ^ req_sub[g_last];
        m_ax = x;
        m_ay = y;
        infl.push_back('{fake_add(x, y), g_last, m_cyc + 2 + LAT});
        m_ptr = (g_last + 1) % N;
      end
      m_cnt = m_cnt + int'(iss_last) - int'(pop_last);
    end
    m_cyc++;
  endtask

  // one clock: inputs were set after the previous negedge
  task automatic step();
    #1;
    model_check();
    if (rsp_valid && rsp_ready) got.push_back(int'(rsp_tag));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic int oh(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  typedef struct {int req; logic sub; logic [W-1:0] x; logic [W-1:0] y;
                  logic [W-1:0] exp_ay; logic [N-1:0] exp_rdy;} vec_t;
  vec_t vt[4];

  initial begin
    int lat, acc, bad;
    int gr[$];
    int exp_rr[8];
    int exp_skip[3];

    vt[0] = '{2, 1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 4'b0100};
    vt[1] = '{0, 1'b1, 32'h3F80_0000, 32'h4000_0000, 32'hC000_0000, 4'b0001};
    vt[2] = '{0, 1'b1, 32'h3F80_0000, 32'hC000_0000, 32'h4000_0000, 4'b0001};
    vt[3] = '{3, 1'b0, 32'hC000_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b1000};
    exp_rr   = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_skip = '{3, 0, 3};

    // reset state, with requests present to show req_ready is held off
    rst = 1'b1;
    step();
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_x[i*W +: W] = $urandom;
      req_y[i*W +: W] = $urandom;
    end
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_add_valid", add_valid, 0);
    chk("rst_add_x", add_x, 0);
    chk("rst_add_y", add_y, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    step();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();

    // table-driven single operations: grant, sign flip, latency, tag, data
    foreach (vt[v]) begin
      req_valid = '0;
      req_valid[vt[v].req] = 1'b1;
      req_sub = '0;
      req_sub[vt[v].req] = vt[v].sub;
      req_x[vt[v].req*W +: W] = vt[v].x;
      req_y[vt[v].req*W +: W] = vt[v].y;
      #1 chk("vec_ready", req_ready, vt[v].exp_rdy);
      step();
      req_valid = '0;
      #1;
      chk("vec_add_valid", add_valid, 1);
      chk("vec_add_x", add_x, vt[v].x);
      chk("vec_add_y", add_y, vt[v].exp_ay);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
        step();
        lat++;
        #1;
      end
      chk("vec_latency", lat, 2 + LAT);
      chk("vec_tag", rsp_tag, vt[v].req);
      chk("vec_data", rsp_data, fake_add(vt[v].x, vt[v].exp_ay));
      step();
    end

    // round-robin fairness with all requesters active
    got.delete();
    req_sub = '0;
    req_valid = '1;
    repeat (8) begin
      #1 gr.push_back(oh(req_ready));
      step();
    end
    req_valid = '0;
    repeat (LAT + 4) step();
    chk("rr_count", gr.size(), 8);
    chk("rr_rsp_count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("rr_grant", gr[i], exp_rr[i]);
      if (i < got.size()) chk("rr_rsp_tag", got[i], exp_rr[i]);
    end

    // backpressure: exactly DEPTH accepts, then one pop buys one accept
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    acc = 0;
    repeat (12) begin
      #1 if (req_ready != 0) acc++;
      step();
    end
    chk("bp_accepts", acc, DEPTH);
    repeat (LAT + 2) step();
    #1 chk("bp_full_ready", req_ready, 0);
    rsp_ready = 1'b1;
    #1 chk("bp_pop_same_cycle", req_ready, 0);
    step();
    rsp_ready = 1'b0;
    #1 chk("bp_new_accept", req_ready, 4'b0010);
    step();
    #1 chk("bp_full_again", req_ready, 0);
    step();
    req_valid = '0;
    got.delete();
    rsp_ready = 1'b1;
    repeat (DEPTH + LAT + 6) step();
    chk("bp_drain_count", got.size(), DEPTH);
    foreach (got[i]) chk("bp_drain_tag", got[i], 1);

    // pointer skip: move ptr to 1, then only requesters 0 and 3 compete
    req_valid = 4'b0001;
    step();
    req_valid = 4'b1001;
    gr.delete();
    repeat (3) begin
      #1 gr.push_back(oh(req_ready));
      step();
    end
    req_valid = '0;
    for (int i = 0; i < 3; i++) chk("skip_grant", gr[i], exp_skip[i]);
    repeat (LAT + 5) step();

    // reset mid-flight: three ops in flight, a one-cycle reset two cycles later
    req_valid = 4'b0111;
    repeat (3) step();
    req_valid = '0;
    repeat (2) step();
    rst = 1'b1;
    req_valid = '1;
    #1 chk("rst_mid_ready", req_ready, 0);
    step();
    rst = 1'b0;
    req_valid = '0;
    bad = 0;
    repeat (LAT + 4) begin
      #1 if (rsp_valid || add_valid || req_ready != 0) bad++;
      step();
    end
    chk("rst_quiet", bad, 0);
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    acc = 0;
    repeat (12) begin
      #1 if (req_ready != 0) acc++;
      step();
    end
    chk("rst_credits", acc, DEPTH);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (DEPTH + LAT + 4) step();

    // randomized traffic against the model
    repeat (600) begin
      req_valid = N'($urandom);
      req_sub   = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_x[i*W +: W] = $urandom;
        req_y[i*W +: W] = $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (DEPTH + LAT + 4) step();
    #1 chk("final_empty", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
